// File: rtl/tx_fifo_param.sv
// Parametrised first-word-fall-through transmit FIFO.
// Sits between the Triple-DES datapath and the I2C slave transmitter.
// Occupancy is kept in its own register rather than decoded from the pointers,
// so full and empty are never ambiguous when the pointers coincide.
// Status flags decode only registered state, so none of them depends
// combinationally on the enables or on flush.
module tx_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_enable,
    input  logic                  flush,
    input  logic                  clear_errors,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic empty_s, full_s;
    logic wr_acc_s, rd_acc_s;
    logic ovf_set_s, unf_set_s;

    assign empty_s = (count_q == {CW{1'b0}});
    assign full_s  = (count_q == DEPTH_C);

    // Decide which requests are accepted and which raise an error this cycle
    always_comb begin
        rd_acc_s  = 1'b0;
        wr_acc_s  = 1'b0;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        if (flush) begin
            rd_acc_s  = 1'b0;
            wr_acc_s  = 1'b0;
            ovf_set_s = 1'b0;
            unf_set_s = 1'b0;
        end else begin
            rd_acc_s  = read_enable & ~empty_s;
            // A full FIFO still takes a write when the head leaves in the same cycle
            wr_acc_s  = write_enable & (~full_s | rd_acc_s);
            ovf_set_s = write_enable & full_s & ~read_enable;
            unf_set_s = read_enable & empty_s;
        end
    end

    // Next-state for pointers, occupancy and sticky error flags
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // A new error in the same cycle as clear_errors keeps the flag set
        if (ovf_set_s) begin
            overflow_d = 1'b1;
        end else if (clear_errors) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (unf_set_s) begin
            underflow_d = 1'b1;
        end else if (clear_errors) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; stale contents are harmless because an empty FIFO drives zeros
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= write_data;
        end
    end

    assign read_data    = empty_s ? {DATA_WIDTH{1'b0}} : mem_q[rd_ptr_q];
    assign fifo_empty   = empty_s;
    assign fifo_full    = full_s;
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_tx_fifo_param.sv
// Scoreboard bench for tx_fifo_param: a queue-based reference model predicts
// occupancy, flags and errors; a separate monitor checks the data leaving the FIFO.
module tb_tx_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 1;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          write_enable;
    logic [DW-1:0] write_data;
    logic          read_enable;
    logic          flush;
    logic          clear_errors;
    logic [DW-1:0] read_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic          almost_empty;
    logic          almost_full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents as a plain queue plus the two sticky error bits
    logic [DW-1:0] mq[$];
    // Scoreboard: every accepted write, in the order it must come back out
    logic [DW-1:0] sb_q[$];
    bit            m_ovf;
    bit            m_unf;

    tx_fifo_param #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .write_enable(write_enable), .write_data(write_data),
        .read_enable(read_enable), .flush(flush), .clear_errors(clear_errors),
        .read_data(read_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: when the DUT presents a head entry that is being consumed, pop the scoreboard
    always @(negedge clk) begin
        if (n_rst && read_enable && !flush && !fifo_empty) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_read", 32'd1, 32'd0);
            end else begin
                chk("read_order", {24'd0, read_data}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic check_status();
        int n;
        n = mq.size();
        chk("count", {{(32-CW){1'b0}}, count}, n);
        chk("fifo_empty", {31'd0, fifo_empty}, (n == 0) ? 32'd1 : 32'd0);
        chk("fifo_full", {31'd0, fifo_full}, (n == DEPTH) ? 32'd1 : 32'd0);
        chk("almost_empty", {31'd0, almost_empty}, (n <= AE) ? 32'd1 : 32'd0);
        chk("almost_full", {31'd0, almost_full}, (n >= AF) ? 32'd1 : 32'd0);
        chk("read_data", {24'd0, read_data}, (n == 0) ? 32'd0 : {24'd0, mq[0]});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("underflow", {31'd0, underflow}, {31'd0, m_unf});
    endtask

    // One clock: drive the request, predict its effect, then check after the edge
    task automatic cycle(input bit we, input logic [DW-1:0] wd, input bit re,
                         input bit fl, input bit ce);
        bit full, empty, rd, wr, ovf_set, unf_set;
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        flush        = fl;
        clear_errors = ce;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (fl) begin
            mq.delete();
            sb_q.delete();
        end else begin
            full  = (mq.size() == DEPTH);
            empty = (mq.size() == 0);
            rd    = re && !empty;
            wr    = we && (!full || rd);
            ovf_set = we && full && !re;
            unf_set = re && empty;
            if (rd) void'(mq.pop_front());
            if (wr) begin
                mq.push_back(wd);
                sb_q.push_back(wd);
            end
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (ce) m_ovf = 1'b0;
        if (unf_set) m_unf = 1'b1;
        else if (ce) m_unf = 1'b0;
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int pw;
        n_rst        = 1'b0;
        write_enable = 1'b0;
        write_data   = 8'h00;
        read_enable  = 1'b0;
        flush        = 1'b0;
        clear_errors = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        check_status();
        @(posedge clk);
        #1;
        check_status();

        // Fill to full, overflow attempt, then drain in order
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Pointer wrap-around
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Simultaneous read+write on full, then on empty
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Sticky underflow and set-wins-over-clear
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(5);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Flush beats a simultaneous write; then refill and reset between edges
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
        write_enable = 1'b0;
        #2;
        n_rst = 1'b0;
        mq.delete();
        sb_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        check_status();
        @(posedge clk);
        #1;
        check_status();
        n_rst = 1'b1;
        idle(2);

        // Randomised traffic in alternating write-heavy and read-heavy phases
        for (int ph = 0; ph < 10; ph++) begin
            pw = (ph % 2 == 0) ? 75 : 30;
            for (int i = 0; i < 200; i++) begin
                cycle($urandom_range(0, 99) < pw, 8'($urandom),
                      $urandom_range(0, 99) < (100 - pw),
                      $urandom_range(0, 99) < 2,
                      $urandom_range(0, 99) < 5);
            end
        end
        idle(1);
        chk("sb_drain", sb_q.size(), mq.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
